// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : bounce_generator
// Purpose  : Emulates a mechanical contact. When the clean input level
//            changes, the output takes the new level on the next edge, then
//            bounces a programmable number of times with pseudo-random gaps
//            (driven by a 16-bit Galois LFSR), and finally holds steady for a
//            fixed settle time before reporting completion.
// Ports    : i_clk      - clock, rising-edge active
//            i_reset    - asynchronous active-high reset
//            i_level    - clean target level to emulate
//            i_bounces  - bounce pairs for the next transition (0..15)
//            o_bouncy   - emulated contact signal (registered)
//            o_busy     - high while a transition is in progress
//            o_done     - one-cycle pulse when a transition completes
// Revision : 1.0 - initial release
// ============================================================================
module bounce_generator #(
  parameter int unsigned MIN_GAP       = 2,
  parameter int unsigned GAP_BITS      = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_level,
  input  logic [3:0] i_bounces,
  output logic       o_bouncy,
  output logic       o_busy,
  output logic       o_done
);

  // Gap arithmetic is wide enough that MIN_GAP (<=255) plus the largest
  // random offset can never wrap.
  localparam int unsigned       c_GW        = GAP_BITS + 8;
  // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
  localparam logic [15:0]       c_LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]       c_LFSR_MASK = 16'hB400;
  localparam logic [c_GW-1:0]   c_MIN_GAP   = c_GW'(MIN_GAP);
  localparam logic [15:0]       c_SETTLE    = 16'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic            r_target;
  logic [4:0]      r_toggles_left;
  logic [c_GW-1:0] r_gap_cnt;
  logic [15:0]     r_settle_cnt;
  logic            r_bouncy;
  logic            r_done;

  logic [15:0]     w_lfsr_next;
  logic [c_GW-1:0] w_gap;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_MASK) : (r_lfsr >> 1);
  assign w_gap       = c_MIN_GAP + c_GW'(r_lfsr[GAP_BITS-1:0]);

  assign o_bouncy = r_bouncy;
  assign o_done   = r_done;
  assign o_busy   = (r_state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_lfsr         <= c_LFSR_INIT;
      r_target       <= 1'b0;
      r_toggles_left <= '0;
      r_gap_cnt      <= '0;
      r_settle_cnt   <= '0;
      r_bouncy       <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // The LFSR free-runs so gap values depend on when a transition starts.
      r_lfsr <= w_lfsr_next;
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_level != r_bouncy) begin
            r_bouncy       <= i_level;
            r_target       <= i_level;
            r_toggles_left <= {i_bounces, 1'b0};
            r_gap_cnt      <= w_gap;
            r_settle_cnt   <= c_SETTLE;
            r_state        <= (i_bounces == 4'd0) ? S_SETTLE : S_BOUNCE;
          end
        end

        S_BOUNCE: begin
          if (r_gap_cnt == c_GW'(1)) begin
            r_gap_cnt <= w_gap;
            // Last toggle lands on the target; the <= guard keeps the
            // counter from ever wrapping below zero.
            if (r_toggles_left <= 5'd1) begin
              r_bouncy       <= r_target;
              r_toggles_left <= '0;
              r_settle_cnt   <= c_SETTLE;
              r_state        <= S_SETTLE;
            end else begin
              r_bouncy       <= ~r_bouncy;
              r_toggles_left <= r_toggles_left - 5'd1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - c_GW'(1);
          end
        end

        S_SETTLE: begin
          if (r_settle_cnt == 16'd1) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_generator
// Purpose  : Directed-vector bench for bounce_generator. The driver pushes the
//            expected outcome of each transition into a queue; a monitor
//            follows o_bouncy edge by edge, checks every gap against a
//            reference LFSR and pops/compares on each o_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

  localparam int          c_MIN_GAP = 2;
  localparam int          c_SETTLE  = 16;
  localparam logic [15:0] c_SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       level = 1'b0;
  logic [3:0] bounces = 4'd0;
  logic       bouncy, busy, done;
  logic       bouncy_s0, busy_s0, done_s0;

  always #5 clk = ~clk;

  bounce_generator #(
    .MIN_GAP(2), .GAP_BITS(4), .SETTLE_CYCLES(16), .SEED(16'hACE1)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_level(level), .i_bounces(bounces),
    .o_bouncy(bouncy), .o_busy(busy), .o_done(done)
  );

  // Zero-seed instance: only its LFSR is inspected.
  bounce_generator #(
    .MIN_GAP(2), .GAP_BITS(4), .SETTLE_CYCLES(16), .SEED(16'h0000)
  ) u_dut_s0 (
    .i_clk(clk), .i_reset(rst), .i_level(level), .i_bounces(bounces),
    .o_bouncy(bouncy_s0), .o_busy(busy_s0), .o_done(done_s0)
  );

  typedef struct {
    int   toggles;
    logic lvl;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor state
  logic [15:0] m_lfsr;
  logic        prev_b;
  bit          active;
  exp_t        cur;
  int          tog, t0, t_last, n, busy_cnt, exp_gap;
  int unsigned sig;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic lvl, input logic [3:0] b);
    exp_t e;
    e.toggles = 1 + 2 * int'(b);
    e.lvl     = lvl;
    q.push_back(e);
  endtask

  task automatic monitor();
    logic [15:0] used;
    bit          tg;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_lfsr = c_SEED;
        prev_b = 1'b0;
        active = 1'b0;
        q.delete();
        n      = 0;
        sig    = 0;
      end else begin
        #1;
        used   = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
        n++;
        sig = sig * 32'd31 + 32'(bouncy);
        tg  = (bouncy !== prev_b);
        prev_b = bouncy;
        if (tg) begin
          if (!active) begin
            if (q.size() == 0) chk("spurious_toggle", 1, 0);
            else begin
              active   = 1'b1;
              cur      = q[0];
              tog      = 1;
              t0       = n;
              t_last   = n;
              busy_cnt = 0;
            end
          end else begin
            tog++;
            chk("gap_exact", n - t_last, exp_gap);
            chk("gap_in_range",
                ((n - t_last) >= c_MIN_GAP && (n - t_last) <= c_MIN_GAP + 15) ? 1 : 0, 1);
            t_last = n;
          end
          exp_gap = c_MIN_GAP + int'(used[3:0]);
        end
        if (active && busy) busy_cnt++;
        if (done) begin
          if (!active) chk("spurious_done", 1, 0);
          else begin
            active = 1'b0;
            void'(q.pop_front());
            chk("toggle_count", tog, cur.toggles);
            chk("final_level", int'(bouncy), int'(cur.lvl));
            chk("settle_cycles", n - t_last, c_SETTLE);
            chk("busy_cycles", busy_cnt, n - t0);
            chk("busy_low_at_done", int'(busy), 0);
          end
        end
      end
    end
  endtask

  task automatic start(input logic lvl, input logic [3:0] b);
    @(negedge clk);
    level   = lvl;
    bounces = b;
    push_exp(lvl, b);
    @(posedge clk);
    #2;
    chk("first_edge_latency", int'(bouncy), int'(lvl));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_budget", (k < budget) ? 1 : 0, 1);
  endtask

  task automatic det_run(output int unsigned s);
    @(negedge clk);
    rst     = 1'b1;
    level   = 1'b0;
    bounces = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        level = 1'b1; bounces = 4'd3; push_exp(1'b1, 4'd3);
      end
      if (c == 200) begin
        level = 1'b0; bounces = 4'd2; push_exp(1'b0, 4'd2);
      end
    end
    s = sig;
  endtask

  task automatic driver();
    logic [15:0] ml;
    int unsigned s1, s2;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_bouncy", int'(bouncy), 0);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    chk("reset_seed0_lfsr", int'(u_dut_s0.r_lfsr), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero seed runs the sequence from 0x0001.
    ml = 16'h0001;
    repeat (20) begin
      @(negedge clk);
      ml = lfsr_step(ml);
      chk("seed0_lfsr", int'(u_dut_s0.r_lfsr), int'(ml));
    end
    chk("seed0_nonzero", (u_dut_s0.r_lfsr != 16'h0000) ? 1 : 0, 1);

    start(1'b1, 4'd0);  wait_idle(100);
    start(1'b0, 4'd2);  wait_idle(200);
    start(1'b1, 4'd3);  wait_idle(300);
    start(1'b0, 4'd15); wait_idle(800);
    start(1'b1, 4'd2);  wait_idle(200);

    // Short pulse during BOUNCE that returns to the target is dropped.
    start(1'b0, 4'd4);
    repeat (4) @(negedge clk);
    level = 1'b1;
    repeat (3) @(negedge clk);
    level = 1'b0;
    wait_idle(300);
    repeat (30) @(negedge clk);
    chk("no_retrigger_busy", int'(busy), 0);

    // Asynchronous reset in the middle of BOUNCE.
    start(1'b1, 4'd5);
    repeat (6) @(negedge clk);
    chk("busy_before_reset", int'(busy), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset_bouncy", int'(bouncy), 0);
    chk("midreset_busy",   int'(busy),   0);
    chk("midreset_done",   int'(done),   0);
    repeat (2) @(negedge clk);
    // Level is still high, so the first edge after release restarts.
    rst = 1'b0;
    push_exp(1'b1, 4'd5);
    @(posedge clk);
    #2;
    chk("post_reset_start", int'(bouncy), 1);
    wait_idle(400);

    // Identical stimulus after identical resets gives identical traces.
    det_run(s1);
    det_run(s2);
    chk("trace_repeat", int'(s1), int'(s2));
  endtask

  initial begin
    fork
      monitor();
      driver();
      begin
        #400000;
        chk("watchdog", 0, 1);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
